// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan controller: FSM encoding and the
// decoder's special nibble codes.
package seg_scan_pkg;

   localparam logic [0:0] ST_GAP  = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_DASH  = 4'hE;

   // True when a higher digit still allows suppression of the digits below it.
   function automatic logic lz_pass(input logic [3:0] nib);
      case (nib)
         4'h0, CODE_BLANK: lz_pass = 1'b1;
         CODE_DASH:        lz_pass = 1'b0;
         default:          lz_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Up-counter with synchronous clear and a terminal-count flag against a
// runtime compare value; times both the gap and show intervals.
module seg_scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic [W-1:0] tc_val_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt_d = clr_i ? '0 : cnt_q + W'(1);
   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == tc_val_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit 7-segment scan controller with frame-synchronous shadow data,
// guard gaps and leading-zero blanking. Define SEG_SCAN_DIM_EN for PWM dimming.
//
//   state   | meaning
//   ST_GAP  | all digits off; code_out already carries the upcoming digit
//   ST_SHOW | digit idx enabled for SCAN_DIV cycles
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000,
   parameter int GAP_CYC  = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_en,
`ifdef SEG_SCAN_DIM_EN
   input  logic [3:0]            bright,
`endif
   output logic [3:0]            code_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_start
);

   localparam int TW = $clog2((SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC);
   localparam int IW = $clog2(DIGITS);

   logic [0:0]               state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [TW-1:0]            cnt, tc_val;
   logic                     tc, wrap, boundary;
   logic [DIGITS-1:0][3:0]   sh_q, sh_d, pb_q, pb_d;
   logic [DIGITS-1:0]        sp_q, sp_d, pbp_q, pbp_d;
   logic                     pend_q, pend_d;
   logic [DIGITS-1:0]        sup;
   logic                     above_ok, suppress, show_d, an_on;
   logic [3:0]               code_d;
   logic                     dp_d;
   logic [DIGITS-1:0]        an_d;

   assign tc_val = (state_q == ST_GAP) ? TW'(GAP_CYC - 1) : TW'(SCAN_DIV - 1);

   seg_scan_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tc),
      .tc_val_i (tc_val),
      .cnt_o    (cnt),
      .tc_o     (tc)
   );

   assign wrap     = (idx_q == IW'(DIGITS - 1));
   assign boundary = (state_q == ST_SHOW) && tc && wrap;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (tc) begin
         if (state_q == ST_GAP) begin
            state_d = ST_SHOW;
         end else begin
            state_d = ST_GAP;
            idx_d   = wrap ? '0 : idx_q + IW'(1);
         end
      end
   end

   // A load landing on the boundary cycle goes straight to the shadow copy.
   always_comb begin
      sh_d   = sh_q;
      sp_d   = sp_q;
      pb_d   = pb_q;
      pbp_d  = pbp_q;
      pend_d = pend_q;
      if (boundary && pend_q) begin
         sh_d   = pb_q;
         sp_d   = pbp_q;
         pend_d = 1'b0;
      end
      if (load) begin
         if (boundary) begin
            sh_d   = data_in;
            sp_d   = dp_in;
            pend_d = 1'b0;
         end else begin
            pb_d   = data_in;
            pbp_d  = dp_in;
            pend_d = 1'b1;
         end
      end
   end

   always_comb begin
      above_ok = 1'b1;
      sup      = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         sup[k]   = above_ok && (sh_d[k] == 4'h0) && (k != 0);
         above_ok = above_ok && lz_pass(sh_d[k]);
      end
   end

   assign suppress = lz_en && sup[idx_d];
   assign code_d   = suppress ? CODE_BLANK : sh_d[idx_d];
   assign show_d   = (state_d == ST_SHOW);
   assign dp_d     = show_d && sp_d[idx_d] && !suppress;

`ifdef SEG_SCAN_DIM_EN
   logic [TW-1:0] timer_d;
   logic [3:0]    bright_q, bright_d;

   assign timer_d  = tc ? '0 : cnt + TW'(1);
   assign bright_d = (tc && (state_q == ST_GAP)) ? bright : bright_q;
   assign an_on    = show_d &&
                     (32'(timer_d) < (32'(bright_d) + 32'd1) * 32'(SCAN_DIV / 16));

   always_ff @(posedge clk) begin
      if (rst) begin
         bright_q <= 4'hF;
      end else begin
         bright_q <= bright_d;
      end
   end
`else
   logic unused_cnt;

   assign unused_cnt = ^cnt;
   assign an_on      = show_d;
`endif

   assign an_d = ~(DIGITS'(an_on) << idx_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_GAP;
         idx_q       <= '0;
         sh_q        <= {DIGITS{CODE_BLANK}};
         sp_q        <= '0;
         pb_q        <= {DIGITS{CODE_BLANK}};
         pbp_q       <= '0;
         pend_q      <= 1'b0;
         code_out    <= CODE_BLANK;
         dp_out      <= 1'b0;
         an          <= '1;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         sp_q        <= sp_d;
         pb_q        <= pb_d;
         pbp_q       <= pbp_d;
         pend_q      <= pend_d;
         code_out    <= code_d;
         dp_out      <= dp_d;
         an          <= an_d;
         frame_start <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Frame-level scoreboard bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=4, GAP_CYC=1).
module tb_seg_scan_ctrl;

   localparam int DG = 4;
   localparam int SD = 4;
   localparam int GC = 1;
   localparam int SLOT = SD + GC;
   localparam int FR = DG * SLOT;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  p;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  code_out;
   logic        dp_out;
   logic [3:0]  an;
   logic        frame_start;

   ent_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   fr_no = 0;

   seg_scan_ctrl #(.DIGITS(DG), .SCAN_DIV(SD), .GAP_CYC(GC)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .load        (load),
      .dp_in       (dp_in),
      .lz_en       (lz_en),
      .code_out    (code_out),
      .dp_out      (dp_out),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Expected {an, code_out, dp_out, frame_start} in cycle c of a frame.
   function automatic logic [9:0] exp_vec(input ent_t e, input int c, input bit lz, input bit fs);
      int         dg;
      bit         gap;
      bit         lead;
      bit         sup;
      logic [3:0] nib;
      logic [3:0] hi;
      logic [3:0] code;
      logic [3:0] anv;
      logic       dp;
      dg   = c / SLOT;
      gap  = (c % SLOT) < GC;
      nib  = e.d[dg*4 +: 4];
      lead = 1'b1;
      for (int k = DG - 1; k > dg; k--) begin
         hi   = e.d[k*4 +: 4];
         lead = lead && ((hi == 4'h0) || (hi == 4'hF));
      end
      sup  = lz && (dg != 0) && (nib == 4'h0) && lead;
      code = sup ? 4'hF : nib;
      dp   = !gap && !sup && e.p[dg];
      anv  = gap ? 4'hF : ~(4'b0001 << dg);
      return {anv, code, dp, (fs && (c == 0))};
   endfunction

   task automatic run_frame(input bit fs0, input int ld_at, input logic [15:0] ld_d,
                            input logic [3:0] ld_p, input int ld2_at, input logic [15:0] ld2_d,
                            input bit lz_next, input int rst_at);
      ent_t e;
      ent_t blank;
      bit   lz;
      bit   pushed;
      blank  = {16'hFFFF, 4'h0};
      lz     = lz_en;
      pushed = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         e = blank;
      end else begin
         e = sb.pop_front();
      end
      for (int c = 0; c < FR; c++) begin
         if (c == rst_at) begin
            rst  = 1'b1;
            load = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("mid_reset", 32'({an, code_out, dp_out, frame_start}),
                32'({4'hF, 4'hF, 1'b0, 1'b0}));
            sb.delete();
            sb.push_back(blank);
            fr_no++;
            return;
         end
         chk($sformatf("f%0d_c%0d", fr_no, c), 32'({an, code_out, dp_out, frame_start}),
             32'(exp_vec(e, c, lz, fs0)));
         load = 1'b0;
         if (c == ld_at) begin
            load    = 1'b1;
            data_in = ld_d;
            dp_in   = ld_p;
            sb.push_back({ld_d, ld_p});
            pushed = 1'b1;
         end
         if (c == ld2_at) begin
            load    = 1'b1;
            data_in = ld2_d;
            dp_in   = ld_p;
            if (pushed) void'(sb.pop_back());
            sb.push_back({ld2_d, ld_p});
            pushed = 1'b1;
         end
         if (c == FR - 1) lz_en = lz_next;
         @(negedge clk);
      end
      load = 1'b0;
      if (!pushed) sb.push_back(e);
      fr_no++;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_hold", 32'({an, code_out, dp_out, frame_start}), 32'({4'hF, 4'hF, 1'b0, 1'b0}));
      sb.push_back({16'hFFFF, 4'h0});
      rst = 1'b0;

      run_frame(1'b0, -1, 16'h0000, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1,  7, 16'h1234, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1, -1, 16'h0000, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1,  3, 16'h1111, 4'h0, 12, 16'h2222, 1'b0, -1);
      run_frame(1'b1, 19, 16'h5678, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1, 10, 16'h0070, 4'h0, -1, 16'h0000, 1'b1, -1);
      run_frame(1'b1, 10, 16'h0000, 4'h0, -1, 16'h0000, 1'b1, -1);
      run_frame(1'b1, 10, 16'hE005, 4'h0, -1, 16'h0000, 1'b1, -1);
      run_frame(1'b1, 10, 16'h0312, 4'b0100, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1, -1, 16'h0000, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1,  3, 16'h9876, 4'hF, -1, 16'h0000, 1'b0, 12);
      run_frame(1'b0, -1, 16'h0000, 4'h0, -1, 16'h0000, 1'b0, -1);
      run_frame(1'b1, -1, 16'h0000, 4'h0, -1, 16'h0000, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
